qam_demod: RTL and testbench

- Coherent QAM-16 demodulator; the receive-side counterpart of the I*cos − Q*sin modulator multiplier.
- Mixes received samples with the local carrier (I branch: ×cos, Q branch: ×−sin) and integrates each branch over one symbol (integrate-and-dump).
- Slices each integral to a symbol level in {−3, −1, +1, +3}.
- Sits after the loopback/channel path. It is fed by the same NCO sin/cos source as the modulator and delivers symbols to the de-mapper.

---
 rtl/qam_pkg.sv | 19 +
 rtl/qam_slicer.sv | 27 ++
 rtl/qam_demod.sv | 98 +++++++++
 tb/tb_qam_demod.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// rtl/qam_pkg.sv - shared types, symbol levels and default threshold for the QAM-16 demodulator
package qam_pkg;

  typedef logic signed [2:0]  sym_t;
  typedef logic signed [7:0]  carrier_t;
  typedef logic signed [9:0]  sample_t;
  typedef logic signed [17:0] prod_t;

  localparam sym_t SYM_P3 = 3'sd3;
  localparam sym_t SYM_P1 = 3'sd1;
  localparam sym_t SYM_M1 = -3'sd1;
  localparam sym_t SYM_M3 = -3'sd3;

  // Midway between the +/-1 and +/-3 integrated levels (2048*N*level).
  function automatic int default_thresh(input int samples_per_sym);
    return 4096 * samples_per_sym;
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// rtl/qam_slicer.sv - four-level decision on an integrated branch sum, ties resolved upward
module qam_slicer
  import qam_pkg::*;
#(
  parameter int W = 22
) (
  input  logic signed [W-1:0] sum_i,
  input  logic signed [W-1:0] thresh_i,
  output sym_t                sym_o
);

  logic signed [W-1:0] neg_thresh;

  assign neg_thresh = -thresh_i;

  always_comb begin
    sym_o = SYM_M3;
    if (sum_i >= thresh_i) begin
      sym_o = SYM_P3;
    end else if (!sum_i[W-1]) begin
      sym_o = SYM_P1;
    end else if (sum_i >= neg_thresh) begin
      sym_o = SYM_M1;
    end
  end

endmodule

// File: rtl/qam_demod.sv
// rtl/qam_demod.sv - coherent QAM-16 demodulator: carrier mix, integrate-and-dump, slice
module qam_demod
  import qam_pkg::*;
#(
  parameter int SAMPLES_PER_SYM = 16,
  parameter int THRESH          = default_thresh(SAMPLES_PER_SYM)
) (
  input  logic     axi_clk,
  input  logic     axi_rstn,
  input  logic     qam_valid,
  input  sample_t  qam_in,
  input  logic     cor_valid,
  input  carrier_t sin,
  input  carrier_t cos,
  input  logic     sym_sync,
  output logic     demod_valid,
  output sym_t     demod_i,
  output sym_t     demod_q
);

  localparam int CW = $clog2(SAMPLES_PER_SYM);
  localparam int AW = 18 + CW;
  localparam logic [CW-1:0]        LAST_IDX = CW'(SAMPLES_PER_SYM - 1);
  localparam logic signed [AW-1:0] THR      = AW'(THRESH);

  logic          accept;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  prod_t         mul_i, mul_q;

  prod_t prod_i_q, prod_q_q;
  logic  p_vld_q, p_first_q, p_last_q;

  logic signed [AW-1:0] acc_i_q, acc_q_q;
  logic signed [AW-1:0] base_i, base_q, sum_i, sum_q;
  sym_t                 dec_i, dec_q;

  assign accept = qam_valid & cor_valid;

  // sym_sync forces this sample to index 0 regardless of the running count.
  always_comb begin
    idx   = sym_sync ? '0 : cnt_q;
    cnt_d = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    mul_i = qam_in * cos;
    mul_q = -(qam_in * sin);
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cnt_q     <= '0;
      prod_i_q  <= '0;
      prod_q_q  <= '0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_vld_q <= accept;
      if (accept) begin
        cnt_q     <= cnt_d;
        prod_i_q  <= mul_i;
        prod_q_q  <= mul_q;
        p_first_q <= (idx == '0);
        p_last_q  <= (idx == LAST_IDX);
      end
    end
  end

  // First sample of a symbol restarts the integral, discarding any aborted partial.
  always_comb begin
    base_i = p_first_q ? '0 : acc_i_q;
    base_q = p_first_q ? '0 : acc_q_q;
    sum_i  = base_i + {{CW{prod_i_q[17]}}, prod_i_q};
    sum_q  = base_q + {{CW{prod_q_q[17]}}, prod_q_q};
  end

  qam_slicer #(.W(AW)) u_slice_i (.sum_i(sum_i), .thresh_i(THR), .sym_o(dec_i));
  qam_slicer #(.W(AW)) u_slice_q (.sum_i(sum_q), .thresh_i(THR), .sym_o(dec_q));

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      demod_valid <= 1'b0;
      demod_i     <= '0;
      demod_q     <= '0;
    end else begin
      demod_valid <= p_vld_q & p_last_q;
      if (p_vld_q) begin
        acc_i_q <= sum_i;
        acc_q_q <= sum_q;
        if (p_last_q) begin
          demod_i <= dec_i;
          demod_q <= dec_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_demod.sv
// tb/tb_qam_demod.sv - scoreboard bench for qam_demod with directed symbol vectors
module tb_qam_demod;

  logic              axi_clk = 1'b0;
  logic              axi_rstn;
  logic              qam_valid;
  logic signed [9:0] qam_in;
  logic              cor_valid;
  logic signed [7:0] sin;
  logic signed [7:0] cos;
  logic              sym_sync;
  logic              demod_valid;
  logic signed [2:0] demod_i;
  logic signed [2:0] demod_q;

  qam_demod dut (
    .axi_clk    (axi_clk),
    .axi_rstn   (axi_rstn),
    .qam_valid  (qam_valid),
    .qam_in     (qam_in),
    .cor_valid  (cor_valid),
    .sin        (sin),
    .cos        (cos),
    .sym_sync   (sym_sync),
    .demod_valid(demod_valid),
    .demod_i    (demod_i),
    .demod_q    (demod_q)
  );

  always #5 axi_clk = ~axi_clk;

  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  typedef struct {
    int i;
    int q;
    int at;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  int cos_t[4] = '{64, 0, -64, 0};
  int sin_t[4] = '{0, 64, 0, -64};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation, value and cycle.
  always @(negedge axi_clk) begin
    if (axi_rstn === 1'b1 && demod_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("demod_i", int'(demod_i), e.i);
        chk("demod_q", int'(demod_q), e.q);
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic drive_sample(input int s, input int c, input int sn, input bit sync);
    qam_in    = 10'(s);
    cos       = 8'(c);
    sin       = 8'(sn);
    sym_sync  = sync;
    qam_valid = 1'b1;
    cor_valid = 1'b1;
    @(posedge axi_clk);
    #1;
    qam_valid = 1'b0;
    cor_valid = 1'b0;
    sym_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    qam_valid = 1'b0;
    cor_valid = 1'b0;
    sym_sync  = 1'b0;
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  task automatic expect_now(input int i, input int q);
    sbq.push_back('{i, q, cyc + 1});
  endtask

  // Modulated symbol: qam_in = I*cos - Q*sin; an unaccepted gap may follow sample gap_after.
  task automatic send_sym(input int si, input int sq, input int n, input bit sync,
                          input int gap_after, input int gap_len, input bit expect_out);
    for (int k = 0; k < n; k++) begin
      int c, s;
      c = cos_t[k % 4];
      s = sin_t[k % 4];
      drive_sample(si * c - sq * s, c, s, sync && (k == 0));
      if (k == n - 1 && expect_out) expect_now(si, sq);
      if (k == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          qam_in    = 10'sd100;
          qam_valid = 1'b0;
          cor_valid = 1'b1;
          sym_sync  = 1'b1;
          @(posedge axi_clk);
          #1;
        end
        cor_valid = 1'b0;
        sym_sync  = 1'b0;
      end
    end
  endtask

  task automatic send_const(input int s, input int n, input bit sync);
    for (int k = 0; k < n; k++) drive_sample(s, 64, 0, sync && (k == 0));
  endtask

  initial begin
    axi_rstn  = 1'b0;
    qam_valid = 1'b0;
    cor_valid = 1'b0;
    sym_sync  = 1'b0;
    qam_in    = '0;
    sin       = '0;
    cos       = '0;
    #1;
    chk("reset_valid", int'(demod_valid), 0);
    chk("reset_i", int'(demod_i), 0);
    chk("reset_q", int'(demod_q), 0);
    repeat (3) @(posedge axi_clk);
    #1;
    axi_rstn = 1'b1;
    idle(2);

    // Basic symbol (3,-1): sums 98304 / -32768.
    send_sym(3, -1, 16, 1'b1, -1, 0, 1'b1);
    idle(4);

    // All 16 pairs back to back; only the first carries sym_sync.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        send_sym(2 * a - 3, 2 * b - 3, 16, (a == 0 && b == 0), -1, 0, 1'b1);
      end
    end
    idle(4);

    // Five-cycle gap after sample 7 with sym_sync held high during the gap.
    send_sym(3, -1, 16, 1'b1, 7, 5, 1'b1);
    idle(4);

    // Re-sync at sample 9 aborts the partial symbol.
    send_sym(1, 3, 9, 1'b1, -1, 0, 1'b0);
    send_sym(-3, 1, 16, 1'b1, -1, 0, 1'b1);
    idle(4);

    // Re-sync on what would have been the last sample.
    send_sym(3, 3, 15, 1'b1, -1, 0, 1'b0);
    send_sym(-1, 3, 16, 1'b1, -1, 0, 1'b1);
    idle(4);

    // Threshold boundaries on the I branch; Q sum is 0 -> +1.
    send_const(64, 16, 1'b1);
    expect_now(3, 1);
    send_const(0, 16, 1'b1);
    expect_now(1, 1);
    send_const(-64, 16, 1'b1);
    expect_now(-1, 1);
    send_const(-64, 15, 1'b1);
    drive_sample(-241, 17, 0, 1'b0);
    expect_now(-3, 1);
    idle(4);

    // Leave a nonzero decision, then reset at sample 10.
    send_sym(-1, 3, 16, 1'b1, -1, 0, 1'b1);
    idle(4);
    send_sym(3, 3, 10, 1'b1, -1, 0, 1'b0);
    axi_rstn = 1'b0;
    #1;
    chk("midreset_valid", int'(demod_valid), 0);
    chk("midreset_i", int'(demod_i), 0);
    chk("midreset_q", int'(demod_q), 0);
    @(posedge axi_clk);
    #1;
    axi_rstn = 1'b1;
    idle(1);
    send_sym(-3, -3, 16, 1'b0, -1, 0, 1'b1);

    for (int w = 0; w < 50 && sbq.size() != 0; w++) begin
      @(posedge axi_clk);
      #1;
    end
    chk("pending_expectations", sbq.size(), 0);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
